regfile_wb_sched: RTL and testbench
===================================

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 Parameter N, default 32, SHALL set the data width of write-back data and WD3.
REQ-002 Parameter NREQ, default 3, SHALL set the number of write-back requesters (0=ALU, 1=load, 2=CSR).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  NREQ  requester i holds a write-back.
REQ-006 req_ready  output  NREQ  requester i write-back accepted this cycle.
REQ-007 req_addr  input  5*NREQ  destination register, slice i for requester i.
REQ-008 req_data  input  N*NREQ  write data, slice i for requester i.
REQ-009 alloc_valid  input  1  issue stage marks a destination register pending.
REQ-010 alloc_addr  input  5  register to mark pending.
REQ-011 rs1_addr, rs2_addr  input  5 each  source registers to hazard-check.
REQ-012 rs1_busy, rs2_busy  output  1 each  source has a pending write.
REQ-013 busy_cnt  output  6  number of pending registers.
REQ-014 WE3  output  1  register-file write enable.
REQ-015 A3  output  5  register-file write address.
REQ-016 WD3  output  N  register-file write data.

Function
REQ-017 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, first valid requester in ascending order modulo NREQ wins.
REQ-019 On a grant to requester g, rr_ptr SHALL become (g+1) mod NREQ on the next edge; with no grant, rr_ptr SHALL hold.
REQ-020 req_ready SHALL be combinational from req_valid and rr_ptr; a requester SHALL hold valid, addr and data stable until ready.
REQ-021 A grant SHALL drive WE3/A3/WD3 from the granted slice on the next edge (one-cycle registered latency); with no grant, WE3 SHALL be 0 next cycle and A3/WD3 SHALL hold.
REQ-022 A granted request to address 0 SHALL be accepted (ready high) but SHALL produce WE3=0.
REQ-023 Scoreboard: 32 busy bits; alloc_valid with alloc_addr!=0 SHALL set busy[alloc_addr] on the next edge; alloc_addr=0 SHALL be ignored.
REQ-024 A grant to address a!=0 SHALL clear busy[a] on the next edge (same edge WE3 rises).
REQ-025 Simultaneous alloc and grant-clear of the same address SHALL leave the bit set (alloc wins).
REQ-026 rs1_busy/rs2_busy SHALL be combinational reads of busy[]; address 0 SHALL always read 0.
REQ-027 rs busy SHALL also read 0 for an address whose write is on WE3/A3 this cycle only if its busy bit is already clear (no bypass of the scoreboard).
REQ-028 busy_cnt SHALL be a registered count equal to the population of busy[], updated incrementally (+1 set, -1 clear, 0 if both or neither change a bit).
REQ-029 A grant to a register not busy SHALL still write and SHALL not decrement busy_cnt.

Reset
REQ-030 rst low at a clock edge SHALL clear busy[], busy_cnt=0, rr_ptr=0, WE3=0, A3=0, WD3=0, regardless of in-flight requests.
REQ-031 While rst is low, req_ready SHALL be all-zero and rs1_busy/rs2_busy SHALL read 0.

Structure
REQ-032 A shared package SHALL hold NREQ, the register-address width (5), register count (32) and requester index constants (ALU=0, LOAD=1, CSR=2).
REQ-033 The round-robin arbiter SHALL be one sub-module, rr_arbiter (inputs valid, ptr; outputs one-hot grant, grant index).
REQ-034 The block SHALL connect directly to gen_purpose_reg write port WE3/A3/WD3 with no additional logic.

Verification
REQ-035 Reset, then all three valid to x5,x6,x7 with data 0xA,0xB,0xC held: grants 0,1,2 on consecutive cycles; WE3 writes x5=0xA, x6=0xB, x7=0xC one cycle after each grant.
REQ-036 alloc x9 at cycle 1, rs1_addr=9: rs1_busy=1 from cycle 2, busy_cnt=1; load writes x9=0x20 -> rs1_busy=0 and busy_cnt=0 the cycle after grant.
REQ-037 Same cycle alloc x4 and granted write to x4 (x4 busy): x4 stays busy, busy_cnt unchanged.
REQ-038 Requester 1 writes x0=0xFFFF: req_ready=1, WE3 stays 0; alloc x0 leaves busy_cnt=0; rs2_addr=0 -> rs2_busy=0.
REQ-039 rst low with 3 registers busy and requests pending: next cycle busy_cnt=0, WE3=0, req_ready=0; after release first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants for the register-file write-back scheduler.
package regfile_wb_sched_pkg;
   localparam int WB_NREQ  = 3;
   localparam int REG_AW   = 5;
   localparam int REG_NUM  = 32;
   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_CSR  = 2;
endpackage

// File: rtl/regfile_wb_sched_arb.sv
// Round-robin arbiter: first valid requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);
   int idx;

   // Walk from the farthest slot back toward ptr so the nearest valid one is left standing.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (valid[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
   end
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates requesters onto the register-file write port and tracks pending destinations.
module regfile_wb_sched
   import regfile_wb_sched_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREQ = WB_NREQ
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [REG_AW*NREQ-1:0]   req_addr,
   input  logic [N*NREQ-1:0]        req_data,
   input  logic                     alloc_valid,
   input  logic [REG_AW-1:0]        alloc_addr,
   input  logic [REG_AW-1:0]        rs1_addr,
   input  logic [REG_AW-1:0]        rs2_addr,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   output logic [5:0]               busy_cnt,
   output logic                     WE3,
   output logic [REG_AW-1:0]        A3,
   output logic [N-1:0]             WD3
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]      rr_ptr, gidx, ptr_nxt;
   logic [NREQ-1:0]    vld, grant;
   logic [REG_NUM-1:0] busy, busy_nxt;
   logic [REG_AW-1:0]  g_addr;
   logic [N-1:0]       g_data;
   logic               gnt, set_en, clr_en, inc, dec;

   // Requests are masked during reset so nothing is acknowledged.
   assign vld = rst ? req_valid : '0;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .valid     (vld),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (gidx)
   );

   assign req_ready = grant;
   assign gnt       = |grant;

   always_comb begin
      g_addr = '0;
      g_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            g_addr = g_addr | req_addr[i*REG_AW +: REG_AW];
            g_data = g_data | req_data[i*N +: N];
         end
      end
   end

   assign ptr_nxt = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);

   assign set_en = alloc_valid && (alloc_addr != '0);
   assign clr_en = gnt && (g_addr != '0);
   // Count moves only when a bit really flips; a same-address alloc keeps the bit set.
   assign inc    = set_en && !busy[alloc_addr];
   assign dec    = clr_en && busy[g_addr] && !(set_en && (alloc_addr == g_addr));

   always_comb begin
      busy_nxt = busy;
      if (clr_en) busy_nxt[g_addr] = 1'b0;
      if (set_en) busy_nxt[alloc_addr] = 1'b1;
   end

   assign rs1_busy = rst && (rs1_addr != '0) && busy[rs1_addr];
   assign rs2_busy = rst && (rs2_addr != '0) && busy[rs2_addr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy     <= '0;
         busy_cnt <= '0;
         rr_ptr   <= '0;
         WE3      <= 1'b0;
         A3       <= '0;
         WD3      <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= busy_cnt + {5'd0, inc} - {5'd0, dec};
         WE3      <= clr_en;
         if (gnt) begin
            rr_ptr <= ptr_nxt;
            A3     <= g_addr;
            WD3    <= g_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench: directed vector table plus a model-driven random phase, write port checked via a queue.
module tb_regfile_wb_sched;
   localparam int N = 32;

   typedef struct {
      logic        rst;
      logic [2:0]  v;
      logic [4:0]  a [3];
      logic [31:0] d [3];
      logic        av;
      logic [4:0]  aa, r1, r2;
      logic [2:0]  er;
      logic        eb1, eb2;
      logic [5:0]  ec;
   } row_t;

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    req_valid, req_ready;
   logic [14:0]   req_addr;
   logic [95:0]   req_data;
   logic          alloc_valid;
   logic [4:0]    alloc_addr, rs1_addr, rs2_addr;
   logic          rs1_busy, rs2_busy;
   logic [5:0]    busy_cnt;
   logic          WE3;
   logic [4:0]    A3;
   logic [N-1:0]  WD3;

   int n_chk = 0, n_fail = 0, cyc = 0;
   wr_t q[$];
   logic [4:0]  last_a;
   logic [31:0] last_d;
   row_t tbl[20];

   regfile_wb_sched #(.N(N), .NREQ(3)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .alloc_valid(alloc_valid),
      .alloc_addr(alloc_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_cnt(busy_cnt),
      .WE3(WE3), .A3(A3), .WD3(WD3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   function automatic row_t mk(logic rs, logic [2:0] v, logic [4:0] a0, a1, a2,
                               logic [31:0] d0, d1, d2, logic av, logic [4:0] aa,
                               logic [4:0] r1, r2, logic [2:0] er, logic eb1, eb2,
                               logic [5:0] ec);
      row_t r;
      r.rst = rs; r.v = v; r.a[0] = a0; r.a[1] = a1; r.a[2] = a2;
      r.d[0] = d0; r.d[1] = d1; r.d[2] = d2; r.av = av; r.aa = aa;
      r.r1 = r1; r.r2 = r2; r.er = er; r.eb1 = eb1; r.eb2 = eb2; r.ec = ec;
      return r;
   endfunction

   // Apply one cycle of inputs at the falling edge, check, and queue the expected write port.
   task automatic apply(input row_t r);
      wr_t e;
      int g;
      rst = r.rst; req_valid = r.v;
      req_addr = {r.a[2], r.a[1], r.a[0]};
      req_data = {r.d[2], r.d[1], r.d[0]};
      alloc_valid = r.av; alloc_addr = r.aa; rs1_addr = r.r1; rs2_addr = r.r2;
      #1;
      chk("req_ready", 64'(req_ready), 64'(r.er));
      chk("rs1_busy", 64'(rs1_busy), 64'(r.eb1));
      chk("rs2_busy", 64'(rs2_busy), 64'(r.eb2));
      chk("busy_cnt", 64'(busy_cnt), 64'(r.ec));
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("WE3", 64'(WE3), 64'(e.we));
         chk("A3", 64'(A3), 64'(e.a));
         chk("WD3", 64'(WD3), 64'(e.d));
      end
      if (!r.rst) begin
         e.we = 1'b0; e.a = '0; e.d = '0;
      end else if (r.er != 3'b000) begin
         g = r.er[0] ? 0 : (r.er[1] ? 1 : 2);
         e.we = (r.a[g] != 5'd0); e.a = r.a[g]; e.d = r.d[g];
      end else begin
         e.we = 1'b0; e.a = last_a; e.d = last_d;
      end
      last_a = e.a; last_d = e.d;
      q.push_back(e);
      cyc++;
   endtask

   initial begin
      row_t r;
      logic [2:0]  pv;
      logic [4:0]  pa [3];
      logic [31:0] pd [3];
      logic [31:0] mbusy;
      int mptr, mcnt, g, idx;

      // rs/addr columns: rst v a0 a1 a2 d0 d1 d2 av aa r1 r2 | er eb1 eb2 cnt
      tbl[0]  = mk(1, 3'b111, 5, 6, 7, 'hA, 'hB, 'hC, 0, 0, 0, 0, 3'b001, 0, 0, 0);
      tbl[1]  = mk(1, 3'b110, 5, 6, 7, 'hA, 'hB, 'hC, 0, 0, 0, 0, 3'b010, 0, 0, 0);
      tbl[2]  = mk(1, 3'b100, 5, 6, 7, 'hA, 'hB, 'hC, 0, 0, 0, 0, 3'b100, 0, 0, 0);
      tbl[3]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 3'b000, 0, 0, 0);
      tbl[4]  = mk(1, 3'b010, 0, 9, 0, 0, 'h20, 0, 0, 0, 9, 0, 3'b010, 1, 0, 1);
      tbl[5]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 3'b000, 0, 0, 0);
      tbl[6]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 4, 0, 3'b000, 0, 0, 0);
      tbl[7]  = mk(1, 3'b100, 0, 0, 4, 0, 0, 'h44, 1, 4, 4, 0, 3'b100, 1, 0, 1);
      tbl[8]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 3'b000, 1, 0, 1);
      tbl[9]  = mk(1, 3'b010, 0, 0, 0, 0, 'hFFFF, 0, 1, 0, 4, 0, 3'b010, 1, 0, 1);
      tbl[10] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 3'b000, 1, 0, 1);
      tbl[11] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2, 4, 1, 3'b000, 1, 1, 2);
      tbl[12] = mk(0, 3'b111, 10, 11, 12, 'h10, 'h11, 'h12, 1, 13, 4, 2, 3'b000, 0, 0, 3);
      tbl[13] = mk(1, 3'b111, 10, 11, 12, 'h10, 'h11, 'h12, 0, 0, 4, 13, 3'b001, 0, 0, 0);
      tbl[14] = mk(1, 3'b110, 10, 11, 12, 'h10, 'h11, 'h12, 0, 0, 0, 0, 3'b010, 0, 0, 0);
      tbl[15] = mk(1, 3'b100, 10, 11, 12, 'h10, 'h11, 'h12, 0, 0, 0, 0, 3'b100, 0, 0, 0);
      tbl[16] = mk(1, 3'b010, 0, 21, 0, 0, 'h21, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
      tbl[17] = mk(1, 3'b011, 20, 22, 0, 'h20, 'h22, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
      tbl[18] = mk(1, 3'b010, 20, 22, 0, 'h20, 'h22, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
      tbl[19] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);

      // Reset with requests pending: nothing may be acknowledged.
      rst = 1'b0; req_valid = 3'b111; req_addr = {5'd3, 5'd2, 5'd1}; req_data = '1;
      alloc_valid = 1'b1; alloc_addr = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rs1_busy", 64'(rs1_busy), 64'd0);
      chk("rst_WE3", 64'(WE3), 64'd0);
      chk("rst_A3", 64'(A3), 64'd0);
      chk("rst_WD3", 64'(WD3), 64'd0);
      chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
      last_a = '0; last_d = '0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         apply(tbl[i]);
      end

      // Random phase against a behavioural model; first cycle resets to a known state.
      pv = '0; mptr = 0; mbusy = '0; mcnt = 0;
      for (int i = 0; i < 3; i++) begin pa[i] = '0; pd[i] = '0; end
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 3; i++)
            if (!pv[i] && $urandom_range(2) == 0) begin
               pv[i] = 1'b1; pa[i] = 5'($urandom_range(7)); pd[i] = $urandom;
            end
         r.rst = (c == 0) ? 1'b0 : ($urandom_range(19) != 0);
         r.v = pv; r.a = pa; r.d = pd;
         r.av = 1'($urandom_range(1)); r.aa = 5'($urandom_range(7));
         r.r1 = 5'($urandom_range(7)); r.r2 = 5'($urandom_range(7));
         g = -1;
         if (r.rst)
            for (int k = 0; k < 3; k++) begin
               idx = (mptr + k) % 3;
               if (g < 0 && pv[idx]) g = idx;
            end
         r.er  = (g >= 0) ? 3'(1 << g) : 3'b000;
         r.eb1 = r.rst && (r.r1 != 0) && mbusy[r.r1];
         r.eb2 = r.rst && (r.r2 != 0) && mbusy[r.r2];
         r.ec  = 6'(mcnt);
         @(negedge clk);
         apply(r);
         if (!r.rst) begin
            mbusy = '0; mptr = 0;
         end else begin
            if (g >= 0) begin
               if (pa[g] != 0) mbusy[pa[g]] = 1'b0;
               pv[g] = 1'b0;
               mptr = (g + 1) % 3;
            end
            if (r.av && r.aa != 0) mbusy[r.aa] = 1'b1;
         end
         mcnt = $countones(mbusy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
